// File: rtl/upsampler_ctrl_pkg.sv
// Shared constants and state encoding for the upsampler sample/symbol controller.
package upsampler_ctrl_pkg;

   localparam int UPS_SAM_DIV  = 4;
   localparam int UPS_SYM_DIV  = 4;
   localparam int UPS_N_BY_4   = 5;
   localparam int UPS_PIPE_LAT = 3;
   localparam int SAMPLE_W     = 18;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/upsampler_strobe_gen.sv
// Polyphase index, sample counter and the sample/symbol strobes.
// Phase rests at its last value so the first enabled cycle is a strobe.
module upsampler_strobe_gen
   import upsampler_ctrl_pkg::*;
#(
   parameter int SAM_DIV = UPS_SAM_DIV,
   parameter int SYM_DIV = UPS_SYM_DIV
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cnt_en,
   input  logic       stb_en,
   input  logic       phase_load,
   output logic [1:0] phase,
   output logic       sam_clk_ena,
   output logic       sym_clk_ena
);

   localparam logic [1:0] PH_LAST  = 2'(SAM_DIV - 1);
   localparam logic [1:0] SYM_LAST = 2'(SYM_DIV - 1);

   logic [1:0] sam_cnt;

   assign sam_clk_ena = stb_en && (phase == PH_LAST);
   assign sym_clk_ena = sam_clk_ena && (sam_cnt == SYM_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase   <= PH_LAST;
         sam_cnt <= '0;
      end else begin
         if (phase_load || !cnt_en)
            phase <= PH_LAST;
         else
            phase <= phase + 2'd1;
         if (sam_clk_ena)
            sam_cnt <= (sam_cnt == SYM_LAST) ? 2'd0 : sam_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/upsampler_ctrl.sv
// Feeds source samples to a polyphase upsampler: strobes, underflow
// detection, flush with zeros on stop, and output-valid tracking.
module upsampler_ctrl
   import upsampler_ctrl_pkg::*;
#(
   parameter int SAM_DIV  = UPS_SAM_DIV,
   parameter int SYM_DIV  = UPS_SYM_DIV,
   parameter int N_BY_4   = UPS_N_BY_4,
   parameter int PIPE_LAT = UPS_PIPE_LAT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                src_valid,
   input  logic [SAMPLE_W-1:0] src_data,
   output logic                src_ready,
   output logic [SAMPLE_W-1:0] x_out,
   output logic                sam_clk_ena,
   output logic                sym_clk_ena,
   output logic [1:0]          phase,
   output logic                out_valid,
   output logic                underflow,
   output logic                busy
);

   localparam int FW   = $clog2(N_BY_4 + 1);
   localparam int WAIT = 4 + PIPE_LAT;
   localparam int WW   = $clog2(WAIT + 1);
   localparam int OW   = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

   localparam logic [FW-1:0] FLUSH_LAST = FW'(N_BY_4 - 1);
   localparam logic [FW-1:0] FLUSH_DONE = FW'(N_BY_4);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT - 1);
   localparam logic [OW-1:0] OV_LAST    = OW'(PIPE_LAT);
   localparam logic [1:0]    PH_PRE     = 2'(SAM_DIV - 2);

   state_t        state;
   logic          stop_req;
   logic [FW-1:0] flush_cnt;
   logic [WW-1:0] wait_cnt;
   logic [OW-1:0] ov_cnt;
   logic          streaming;
   logic          flush_done;
   logic          stb_en;
   logic          drain_exit;

   assign streaming  = (state == ST_RUN) || (state == ST_DRAIN);
   assign flush_done = (flush_cnt == FLUSH_DONE);
   // Once the zero flush is complete only the pipeline tail is waited out.
   assign stb_en     = (state == ST_RUN) || ((state == ST_DRAIN) && !flush_done);
   assign drain_exit = (state == ST_DRAIN) && flush_done && (wait_cnt == WAIT_LAST);
   assign src_ready  = sam_clk_ena && (state == ST_RUN);
   assign busy       = (state != ST_IDLE);

   upsampler_strobe_gen #(
      .SAM_DIV (SAM_DIV),
      .SYM_DIV (SYM_DIV)
   ) u_strobe (
      .clk         (clk),
      .reset       (reset),
      .cnt_en      (streaming),
      .stb_en      (stb_en),
      .phase_load  (drain_exit),
      .phase       (phase),
      .sam_clk_ena (sam_clk_ena),
      .sym_clk_ena (sym_clk_ena)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         stop_req  <= 1'b0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
         ov_cnt    <= '0;
         x_out     <= '0;
         out_valid <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // First sample's phase-0 product leaves the adder tree PIPE_LAT+1 clocks after its strobe.
         if (streaming && !out_valid) begin
            if (ov_cnt == OV_LAST)
               out_valid <= 1'b1;
            else
               ov_cnt <= ov_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               stop_req  <= 1'b0;
               flush_cnt <= '0;
               wait_cnt  <= '0;
               ov_cnt    <= '0;
               if (run)
                  state <= ST_PRIME;
            end
            ST_PRIME: begin
               if (!run)
                  state <= ST_IDLE;
               else if (src_valid)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (sam_clk_ena) begin
                  x_out <= src_valid ? src_data : '0;
                  if (!src_valid)
                     underflow <= 1'b1;
               end
               if (!run)
                  stop_req <= 1'b1;
               // Stop request is honoured only on the last phase so the period completes.
               if ((stop_req || !run) && (phase == PH_PRE)) begin
                  state    <= ST_DRAIN;
                  stop_req <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (sam_clk_ena) begin
                  x_out     <= '0;
                  flush_cnt <= flush_cnt + 1'b1;
                  if (flush_cnt == FLUSH_LAST)
                     wait_cnt <= WW'(1);
               end else if (flush_done) begin
                  if (wait_cnt == WAIT_LAST) begin
                     state     <= ST_IDLE;
                     out_valid <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_upsampler_ctrl.sv
// Directed bench for upsampler_ctrl: streaming, underflow, stop/flush,
// run toggling during flush, asynchronous reset and PRIME abort.
module tb_upsampler_ctrl;
   import upsampler_ctrl_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                run = 1'b0;
   logic                src_valid = 1'b0;
   logic [SAMPLE_W-1:0] src_data = '0;
   logic                src_ready;
   logic [SAMPLE_W-1:0] x_out;
   logic                sam_clk_ena;
   logic                sym_clk_ena;
   logic [1:0]          phase;
   logic                out_valid;
   logic                underflow;
   logic                busy;

   int          errs = 0;
   int          checks = 0;
   logic [31:0] exp_x;
   logic        exp_uf;
   bit          stb;

   localparam logic [SAMPLE_W-1:0] D = 18'h1ABCD;

   always #5 clk = ~clk;

   upsampler_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .x_out       (x_out),
      .sam_clk_ena (sam_clk_ena),
      .sym_clk_ena (sym_clk_ena),
      .phase       (phase),
      .out_valid   (out_valid),
      .underflow   (underflow),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_phase", phase, 3);
      chk("rst_sam", sam_clk_ena, 0);
      chk("rst_sym", sym_clk_ena, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", x_out, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_uf", underflow, 0);
      chk("rst_rdy", src_ready, 0);

      reset = 1'b0; run = 1'b1; src_valid = 1'b1; src_data = 1;
      tick();
      chk("prime_busy", busy, 1);
      chk("prime_sam", sam_clk_ena, 0);
      chk("prime_phase", phase, 3);

      // k=0 is the first RUN cycle; underflow at k=40, stop at k=61
      exp_x = 0; exp_uf = 0;
      for (int k = 0; k < 96; k++) begin
         tick();
         run = (k < 61);
         src_valid = (k != 40);
         src_data = SAMPLE_W'(k / 4 + 1);
         stb = (k % 4 == 0) && (k <= 80);
         chk("a_phase", phase, (k < 87) ? (3 + k) % 4 : 3);
         chk("a_sam", sam_clk_ena, stb);
         chk("a_sym", sym_clk_ena, stb && ((k / 4) % 4 == 3));
         chk("a_rdy", src_ready, stb && (k < 64));
         chk("a_ov", out_valid, (k >= 4) && (k < 87));
         chk("a_busy", busy, k < 87);
         chk("a_x", x_out, exp_x);
         chk("a_uf", underflow, exp_uf);
         if (stb) begin
            if (k < 64) begin
               exp_x = src_valid ? 32'(src_data) : 0;
               if (!src_valid) exp_uf = 1;
            end else begin
               exp_x = 0;
            end
         end
      end

      // Restart, stop at once, toggle run during the flush
      run = 1'b1; src_valid = 1'b1; src_data = D;
      for (int m = 0; m < 40; m++) begin
         tick();
         run = !((m >= 2 && m < 7) || (m >= 10 && m < 14));
         stb = (m == 1) || (m == 5) || (m == 9) || (m == 13) || (m == 17) || (m == 21) ||
               (m >= 30 && (m - 30) % 4 == 0);
         chk("b_sam", sam_clk_ena, stb);
         chk("b_rdy", src_ready, (m == 1) || (m >= 30 && (m - 30) % 4 == 0));
         chk("b_busy", busy, m != 28);
         chk("b_phase", phase, (m == 0 || m == 28 || m == 29) ? 3 :
                               (m < 28) ? (m + 2) % 4 : (m + 1) % 4);
         chk("b_ov", out_valid, (m >= 5 && m < 28) || m >= 34);
         chk("b_x", x_out, ((m >= 2 && m <= 5) || m >= 31) ? 32'(D) : 0);
         chk("b_uf", underflow, 1);
      end

      // Asynchronous reset in the middle of a cycle
      #2 reset = 1'b1;
      #1;
      chk("c_phase", phase, 3);
      chk("c_sam", sam_clk_ena, 0);
      chk("c_sym", sym_clk_ena, 0);
      chk("c_busy", busy, 0);
      chk("c_x", x_out, 0);
      chk("c_ov", out_valid, 0);
      chk("c_uf", underflow, 0);
      chk("c_rdy", src_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("c_hold_sam", sam_clk_ena, 0);
         chk("c_hold_busy", busy, 0);
      end

      // PRIME waits for data, and run=0 there aborts to IDLE
      reset = 1'b0; run = 1'b1; src_valid = 1'b0;
      tick();
      chk("d_prime_busy", busy, 1);
      chk("d_prime_sam", sam_clk_ena, 0);
      tick();
      chk("d_wait_busy", busy, 1);
      chk("d_wait_phase", phase, 3);
      run = 1'b0;
      tick();
      chk("d_abort_busy", busy, 0);
      run = 1'b1; src_valid = 1'b1; src_data = 7;
      tick();
      chk("d_prime2_sam", sam_clk_ena, 0);
      tick();
      chk("d_run_sam", sam_clk_ena, 1);
      chk("d_run_phase", phase, 3);
      chk("d_run_rdy", src_ready, 1);
      chk("d_run_sym", sym_clk_ena, 0);
      tick();
      chk("d_x", x_out, 7);
      chk("d_phase", phase, 0);
      chk("d_uf", underflow, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
